// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/done handshake and an iterative
// shift-and-add multiplier.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            request; sampled only while o_busy=0
//   i_op[3:0]          operation code
//   i_a, i_b           operands, captured with i_start
//   o_busy             high while a multiply is iterating
//   o_done             one-cycle pulse when result/flags update
//   o_result           registered result, held until the next o_done
//   o_zero             result==0
//   o_carry            add carry-out / sub borrow, else 0
//   o_overflow         signed overflow for add/sub, else 0
//
// Single-cycle ops are computed from the live inputs and registered on the
// start edge. Multiply runs exactly WIDTH iterations (no early exit), so
// the latency is fixed.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_carry, r_ovf, r_done;

  logic [WIDTH:0]   w_sum, w_diff;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res, w_acc_nxt;
  logic             w_c, w_v;
  logic             w_accept, w_mul_last;

  // Extra top bit: carry-out for add, borrow (a<b unsigned) for sub.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SHW-1:0];

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_mul_last = (r_state == MUL) && (r_cnt == CNT_LAST);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle result and flags; multiply and reserved codes fall to 0.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_SLL:  w_res = i_a << w_sh;
      OP_SRL:  w_res = i_a >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(i_a) >>> w_sh);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start && (i_op == OP_MUL)) w_state_nxt = MUL;
      MUL:     if (r_cnt == CNT_LAST)           w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (i_op == OP_MUL) begin
          r_mcand  <= i_a;
          r_mplier <= i_b;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_result <= w_res;
          r_zero   <= ~|w_res;
          r_carry  <= w_c;
          r_ovf    <= w_v;
          r_done   <= 1'b1;
        end
      end else if (r_state == MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHW'(1);
        if (w_mul_last) begin
          r_result <= w_acc_nxt;
          r_zero   <= ~|w_acc_nxt;
          r_carry  <= 1'b0;
          r_ovf    <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = (r_state == MUL);
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_carry    = r_carry;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): stimulus pushes expected
// responses; a negedge monitor pops one per done pulse and compares.
module tb_seq_alu;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z, c, v;
  } exp_t;

  logic        clk, rst_n, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, carry, ovf;
  logic [31:0] result;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  seq_alu #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_result(result),
    .o_zero(zero), .o_carry(carry), .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, {29'd0, zero, carry, ovf, result},
                    {29'd0, e.z, e.c, e.v, e.res});
        chk({e.name, "_busy"}, {63'd0, busy}, 64'd0);
      end
    end
  end

  // Issue one start for one cycle; called right after a posedge+1 or negedge.
  task automatic go(input string name, input logic [3:0] o, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] er,
                    input logic ez, input logic ec, input logic ev);
    exp_t e;
    e.name = name; e.res = er; e.z = ez; e.c = ec; e.v = ev;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, busy_bad;
    start = 0; op = 0; a = 0; b = 0; rst_n = 0;
    #12;
    chk("reset_state", {58'd0, busy, done, zero, carry, ovf, 1'b0} | {32'd0, result},
                       {58'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1;
    idle(1);

    go("add_ovf",  4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1);
    go("add_wrap", 4'h0, 32'hFFFFFFFF, 32'h1, 32'h0,        1, 1, 0);
    go("sub_brw",  4'h1, 32'd3,        32'd5, 32'hFFFFFFFE, 0, 1, 0);
    go("sub_sovf", 4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1);
    go("and",      4'h2, 32'hF0F0,     32'hFF00, 32'hF000,  0, 0, 0);
    go("or",       4'h3, 32'hF0F0,     32'h0F00, 32'hFFF0,  0, 0, 0);
    go("xor",      4'h4, 32'hFFFF,     32'hFFFF, 32'h0,     1, 0, 0);
    go("slt",      4'h5, 32'hFFFFFFFF, 32'h1, 32'h1,        0, 0, 0);
    go("sltu",     4'h6, 32'hFFFFFFFF, 32'h1, 32'h0,        1, 0, 0);
    go("nor",      4'h7, 32'h0,        32'h0, 32'hFFFFFFFF, 0, 0, 0);
    go("sll_b21",  4'h8, 32'h1,        32'h21, 32'h2,       0, 0, 0);
    go("sll_b20",  4'h8, 32'h5,        32'h20, 32'h5,       0, 0, 0);
    go("srl31",    4'h9, 32'h80000000, 32'd31, 32'h1,       0, 0, 0);
    go("sra4",     4'hA, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0);
    idle(2);

    // Multiply latency: busy in cycles 1..32 after the start edge, done in 33.
    go("mul", 4'hB, 32'd12345, 32'd6789, 32'h04FED79D, 0, 0, 0);
    busy_bad = 0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin k = i; break; end
      if (!busy) busy_bad++;
    end
    chk("mul_done_cycle", 64'(k), 64'd33);
    chk("mul_busy_cycles", 64'(busy_bad), 64'd0);
    idle(1);

    go("mul_wrap", 4'hB, 32'h10000, 32'h10000, 32'h0, 1, 0, 0);
    idle(40);

    // Start during busy is ignored: only the multiply's done may appear.
    go("mul_3x5", 4'hB, 32'd3, 32'd5, 32'd15, 0, 0, 0);
    idle(5);
    op = 4'h0; a = 32'd1; b = 32'd1; start = 1'b1;
    idle(3);
    start = 1'b0;
    idle(40);

    go("illegal", 4'hD, 32'hFFFF, 32'hFFFF, 32'h0, 1, 0, 0);
    idle(2);

    // Back-to-back single-cycle ops: done on consecutive cycles.
    go("b2b_add", 4'h0, 32'd2,  32'd3,  32'd5,  0, 0, 0);
    go("b2b_sub", 4'h1, 32'd10, 32'd4,  32'd6,  0, 0, 0);
    go("b2b_xor", 4'h4, 32'hFF, 32'h0F, 32'hF0, 0, 0, 0);
    idle(3);

    // Reset mid-multiply: outputs clear at once and no done follows.
    op = 4'hB; a = 32'd7; b = 32'd9; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(9);
    #2 rst_n = 0;
    #1;
    chk("midmul_reset", {58'd0, busy, done, zero, carry, ovf, 1'b0} | {32'd0, result},
                        {58'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1;
    idle(40);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
